bcd_display_scanner: RTL and testbench
======================================

Name: bcd_display_scanner

Overview:
Time-multiplexed 7-segment display driver. It accepts a packed NUM_DIGITS-digit BCD word through a valid/ready handshake and double-buffers it. It then scans the digits one at a time, driving active-low segment, decimal-point and anode lines. It sits directly upstream of seven_segment_to_bcd: seg_out uses the same active-low encoding, bit6=a .. bit0=g, so that block can decode it back in loopback.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (>=1)
REFRESH_DIV, 1000, clock cycles per digit slot (> BLANK_CYCLES)
BLANK_CYCLES, 2, anti-ghosting cycles at start of each slot with all anodes off

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; asynchronous, active-high
load_valid  in  1  new display word offered
load_ready  out  1  shadow buffer free; transfer occurs when load_valid&&load_ready
load_bcd  in  4*NUM_DIGITS  BCD digits; [3:0]=digit 0 (rightmost, least significant)
load_dp  in  NUM_DIGITS  decimal point per digit, 1=lit
lz_suppress  in  1  blank leading zeros, sampled live
seg_out  out  7  active-low segments a..g (bit6=a)
dp_out  out  1  active-low decimal point
an_out  out  NUM_DIGITS  active-low anode enables, one-hot-low while driving
digit_idx  out  $clog2(NUM_DIGITS) (min 1)  digit currently in slot
frame_done  out  1  one-cycle pulse on last cycle of digit NUM_DIGITS-1 slot

Behaviour:
- Reset, async, takes effect immediately:
  - seg_out=7'b1111111, dp_out=1, an_out all 1, digit_idx=0, frame_done=0, load_ready=1.
  - Active buffer loaded with 4'hF per digit (blank) and dp=0.
  - Shadow buffer cleared, pending=0, slot counter=0, FSM=BLANK.
- Handshake:
  - load_ready = !pending (registered).
  - On accept, shadow <= {load_bcd, load_dp} and pending <= 1.
  - load_valid is ignored while load_ready=0.
- Frame-boundary transfer:
  - In the frame_done cycle, if pending=1: active <= shadow, pending <= 0. load_ready returns high the next cycle.
  - If an accept and frame_done coincide while pending=0, the word goes to shadow and is transferred at the following frame end.
  - The displayed value never changes mid-frame.
- Slot counter runs 0..REFRESH_DIV-1, then wraps and digit_idx advances (N-1 wraps to 0).
- FSM, two states:
  - BLANK: counter < BLANK_CYCLES. an_out all 1, seg_out=7'h7F, dp_out=1.
  - DRIVE: counter >= BLANK_CYCLES. an_out[digit_idx]=0, others 1; seg_out=decode(active digit); dp_out=~dp[digit_idx].
  - BLANK->DRIVE when counter==BLANK_CYCLES-1. DRIVE->BLANK on counter wrap.
  - If BLANK_CYCLES=0, FSM stays in DRIVE.
- All outputs are registered: values reflect the state one cycle after the counter/idx update.
- Decode, active-low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - 10..15 decode to 1111111 (blank).
- Leading-zero suppression, when lz_suppress=1:
  - Digits from NUM_DIGITS-1 downward that equal 0, up to the first nonzero digit, decode to blank. The anode is still driven.
  - Digit 0 is never suppressed.
  - DP is still shown on suppressed digits.

Decomposition:
- Package seg7_pkg: SEG_W=7, SEG_0..SEG_9 and SEG_BLANK constants, BCD_W=4. Shared with seven_segment_to_bcd.
- Sub-module bcd_to_seven_segment: combinational 4-bit to 7-bit decoder using the package constants, the exact inverse of seven_segment_to_bcd.

Test Plan:
1. Reset mid-DRIVE slot -> same cycle, without a clock edge: an_out=4'b1111, seg_out=7'h7F, dp_out=1, load_ready=1. After release, first frame is fully blank.
2. NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2; load 16'h1234 -> after next frame_done:
   - digit0: an_out=1110, seg=1001100
   - digit1: an_out=1101, seg=0000110
   - digit2: an_out=1011, seg=0010010
   - digit3: an_out=0111, seg=1001111
   - Each slot: 2 blank cycles, then 6 driven cycles; frame_done every 32 cycles.
3. lz_suppress=1, load 16'h0070 -> digits 3 and 2 show seg=1111111; digit1=0001111; digit0=0000001. With lz_suppress=0, digit3 and digit2 show 0000001.
4. Load 16'h1111, then offer 16'h2222 mid-frame -> load_ready=0, second word not accepted. At frame_done 1111 goes active and load_ready rises; 2222 is accepted and shown from the frame after.
5. Load 16'h00A9 with load_dp=4'b0100 -> digit0=0000100, digit1 blank (code A), dp_out=0 only in digit2 slot. seg_out looped through seven_segment_to_bcd returns 9 for digit0.
6. Loopback sweep of digits 0..9 through seven_segment_to_bcd -> bcd_out equals the loaded digit in every DRIVE cycle.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment constants, active-low, bit6=a .. bit0=g.
// Used by both the BCD encoder and the segment-to-BCD decoder.
package seg7_pkg;

  localparam int SEG_W = 7;
  localparam int BCD_W = 4;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_st_e;

endpackage

// File: rtl/bcd_to_seven_segment.sv
// BCD digit to active-low 7-segment pattern.
// Codes 10..15 light nothing.
module bcd_to_seven_segment
  import seg7_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  output logic [SEG_W-1:0] seg_o
);

  // Pure lookup; anything outside 0..9 is blank.
  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Multiplexed 7-segment scanner with double-buffered BCD word.
// Shadow word moves to the active buffer only at frame end.
module bcd_display_scanner
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_bcd,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  input  logic                    lz_suppress,
  output logic [SEG_W-1:0]        seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic [IW-1:0]           digit_idx,
  output logic                    frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam scan_st_e ST_RST = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  scan_st_e                st_q, st_d;
  logic [4*NUM_DIGITS-1:0] act_bcd_q, sh_bcd_q;
  logic [NUM_DIGITS-1:0]   act_dp_q, sh_dp_q;
  logic                    pend_q;
  logic                    wrap, frame_end, accept;
  logic [BCD_W-1:0]        cur_bcd;
  logic                    cur_dp;
  logic [SEG_W-1:0]        dec_seg;
  logic [NUM_DIGITS-1:0]   lead_zero;
  logic                    suppress;
  logic [SEG_W-1:0]        seg_d;
  logic                    dp_d;
  logic [NUM_DIGITS-1:0]   an_d;

  assign wrap       = (cnt_q == CW'(REFRESH_DIV - 1));
  assign frame_end  = wrap && (idx_q == IW'(NUM_DIGITS - 1));
  assign accept     = load_valid && !pend_q;
  assign load_ready = !pend_q;
  assign cur_bcd    = act_bcd_q[4*int'(idx_q) +: 4];
  assign cur_dp     = act_dp_q[idx_q];

  // Slot counter and digit index advance.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (wrap) begin
      cnt_d = '0;
      if (idx_q == IW'(NUM_DIGITS - 1)) idx_d = '0;
      else                              idx_d = idx_q + IW'(1);
    end
  end

  // Counter, index and FSM state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      st_q  <= ST_RST;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      st_q  <= st_d;
    end
  end

  // BLANK for the first cycles of a slot, DRIVE for the rest.
  always_comb begin
    st_d = st_q;
    if (BLANK_CYCLES == 0) begin
      st_d = ST_DRIVE;
    end else begin
      case (st_q)
        ST_BLANK: if (cnt_q == CW'(BLANK_CYCLES - 1)) st_d = ST_DRIVE;
        ST_DRIVE: if (wrap) st_d = ST_BLANK;
        default:  st_d = ST_BLANK;
      endcase
    end
  end

  // Shadow capture on handshake, shadow-to-active only at frame end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_bcd_q <= {NUM_DIGITS{4'hF}};
      act_dp_q  <= '0;
      sh_bcd_q  <= '0;
      sh_dp_q   <= '0;
      pend_q    <= 1'b0;
    end else begin
      if (accept) begin
        sh_bcd_q <= load_bcd;
        sh_dp_q  <= load_dp;
        pend_q   <= 1'b1;
      end else if (frame_end && pend_q) begin
        act_bcd_q <= sh_bcd_q;
        act_dp_q  <= sh_dp_q;
        pend_q    <= 1'b0;
      end
    end
  end

  // Zero run from the top digit down to the current one.
  always_comb begin
    lead_zero = '0;
    lead_zero[NUM_DIGITS-1] = (act_bcd_q[4*NUM_DIGITS-1 -: 4] == 4'd0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      lead_zero[i] = lead_zero[i+1] && (act_bcd_q[4*i +: 4] == 4'd0);
    end
    suppress = lz_suppress && (idx_q != '0) && lead_zero[idx_q];
  end

  bcd_to_seven_segment u_dec (
    .bcd_i (cur_bcd),
    .seg_o (dec_seg)
  );

  // Output decode from FSM state; DP stays visible on blanked zeros.
  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (st_q == ST_DRIVE) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = suppress ? SEG_BLANK : dec_seg;
      dp_d  = ~cur_dp;
    end
  end

  // Registered outputs, one cycle behind the scan position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_out     <= '1;
      seg_out    <= SEG_BLANK;
      dp_out     <= 1'b1;
      digit_idx  <= '0;
      frame_done <= 1'b0;
    end else begin
      an_out     <= an_d;
      seg_out    <= seg_d;
      dp_out     <= dp_d;
      digit_idx  <= idx_q;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench: accepted words queue up, a monitor
// predicts every output cycle from the scan timeline.
module tb_bcd_display_scanner;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FR = ND * RD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [15:0]   load_bcd = '0;
  logic [3:0]    load_dp = '0;
  logic          lz_suppress = 1'b0;
  logic [6:0]    seg_out;
  logic          dp_out;
  logic [3:0]    an_out;
  logic [1:0]    digit_idx;
  logic          frame_done;

  bcd_display_scanner #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_bcd    (load_bcd),
    .load_dp     (load_dp),
    .lz_suppress (lz_suppress),
    .seg_out     (seg_out),
    .dp_out      (dp_out),
    .an_out      (an_out),
    .digit_idx   (digit_idx),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] b;
    logic [3:0]  d;
    int          stamp;
  } word_t;

  word_t       q[$];
  int          checks = 0;
  int          errors = 0;
  int          n = 0;
  logic [15:0] cur_b = 16'hFFFF;
  logic [3:0]  cur_d = '0;
  logic        lz_prev = 1'b0;
  logic [6:0]  segt [16];

  initial begin
    segt[0] = 7'b0000001; segt[1] = 7'b1001111;
    segt[2] = 7'b0010010; segt[3] = 7'b0000110;
    segt[4] = 7'b1001100; segt[5] = 7'b0100100;
    segt[6] = 7'b0100000; segt[7] = 7'b0001111;
    segt[8] = 7'b0000000; segt[9] = 7'b0000100;
    for (int k = 10; k < 16; k++) segt[k] = 7'h7F;
  end

  function automatic int seg2bcd(input logic [6:0] s);
    for (int k = 0; k < 10; k++) if (segt[k] == s) return k;
    return 15;
  endfunction

  // Monitor: predicts outputs following edge n of the scan.
  always @(negedge clk) begin
    int p, i, w, dg;
    logic drv, sup, e_rdy, e_fd;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp;
    if (rst) begin
      n = 0;
      cur_b = 16'hFFFF;
      cur_d = '0;
      q.delete();
      lz_prev = lz_suppress;
    end else begin
      n++;
      p = n - 1;
      i = (p / RD) % ND;
      w = p % RD;
      drv = (w >= BC);
      dg = int'((cur_b >> (4 * i)) & 16'hF);
      sup = lz_prev && (i != 0) && ((cur_b >> (4 * i)) == 0);
      e_an = 4'hF;
      e_seg = 7'h7F;
      e_dp = 1'b1;
      if (drv) begin
        e_an[i] = 1'b0;
        e_seg = sup ? 7'h7F : segt[dg];
        e_dp = ~cur_d[i];
      end
      e_fd = ((p % FR) == FR - 1);
      if (e_fd && q.size() > 0 && q[0].stamp < n) begin
        cur_b = q[0].b;
        cur_d = q[0].d;
        void'(q.pop_front());
      end
      e_rdy = !(q.size() > 0 && q[0].stamp <= n);
      checks++;
      if (an_out !== e_an || seg_out !== e_seg || dp_out !== e_dp ||
          digit_idx !== 2'(i) || frame_done !== e_fd ||
          load_ready !== e_rdy) begin
        errors++;
        if (errors < 30)
          $display("FAIL scan n=%0d an=%b/%b seg=%b/%b dp=%b/%b idx=%0d/%0d fd=%b/%b rdy=%b/%b (got/exp)",
                   n, an_out, e_an, seg_out, e_seg, dp_out, e_dp,
                   digit_idx, i, frame_done, e_fd, load_ready, e_rdy);
      end
      if (drv && !sup && dg < 10) begin
        checks++;
        if (seg2bcd(seg_out) != dg) begin
          errors++;
          if (errors < 30)
            $display("FAIL loopback n=%0d got %0d exp %0d",
                     n, seg2bcd(seg_out), dg);
        end
      end
      lz_prev = lz_suppress;
    end
  end

  task automatic send(input logic [15:0] b, input logic [3:0] d);
    int t;
    bit done;
    t = 0;
    done = 0;
    @(posedge clk); #1;
    load_valid = 1'b1;
    load_bcd = b;
    load_dp = d;
    while (!done && t < 300) begin
      @(negedge clk); #1;
      if (load_ready) begin
        q.push_back('{b: b, d: d, stamp: n + 1});
        done = 1;
      end
      @(posedge clk); #1;
      t++;
    end
    load_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout word=%h not accepted in 300 cycles", b);
    end
  endtask

  task automatic cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic release_rst();
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int t;
    logic [15:0] rb;
    cycles(3);
    release_rst();
    cycles(FR + 4);

    send(16'h1234, 4'b0000);
    t = 0;
    while (an_out === 4'hF && t < 200) begin
      @(negedge clk);
      t++;
    end
    while (an_out === 4'hF && t < 400) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (an_out === 4'hF) begin
      errors++;
      $display("FAIL drive_wait an=%b never driven", an_out);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (an_out !== 4'hF || seg_out !== 7'h7F || dp_out !== 1'b1 ||
        load_ready !== 1'b1 || frame_done !== 1'b0 ||
        digit_idx !== 2'd0) begin
      errors++;
      $display("FAIL async_reset an=%b seg=%b dp=%b rdy=%b fd=%b idx=%0d",
               an_out, seg_out, dp_out, load_ready, frame_done, digit_idx);
    end
    cycles(3);
    release_rst();
    cycles(FR + 3);

    send(16'h1234, 4'b0000);
    cycles(3 * FR);

    lz_suppress = 1'b1;
    send(16'h0070, 4'b0000);
    cycles(2 * FR);
    lz_suppress = 1'b0;
    cycles(2 * FR);

    send(16'h1111, 4'b0000);
    cycles(5);
    send(16'h2222, 4'b0000);
    cycles(2 * FR);

    send(16'h00A9, 4'b0100);
    cycles(2 * FR);

    for (int d = 0; d < 10; d++) begin
      rb = {4{4'(d)}};
      send(rb, 4'(d));
    end
    cycles(FR);

    for (int r = 0; r < 25; r++) begin
      rb = 16'($urandom);
      if ($urandom_range(0, 2) == 0) rb = rb & 16'h00FF;
      if ($urandom_range(0, 3) == 0) rb = rb & 16'h000F;
      if ($urandom_range(0, 3) == 0) lz_suppress = ~lz_suppress;
      send(rb, 4'($urandom));
      cycles($urandom_range(0, 40));
    end

    t = 0;
    while (q.size() > 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain queue=%0d words never displayed", q.size());
    end
    cycles(2 * FR);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
